// File: rtl/arithmetic_pkg.sv
// Shared arithmetic definitions: FSM state encoding and counter sizing for the bit-serial datapaths.
package arithmetic_pkg;

  localparam int unsigned N_DEF = 8;
  localparam int unsigned CNT_W = $clog2(N_DEF);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bit counter width for an N-bit serial operation; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/full_add_cell.sv
// Combinational 1-bit full adder cell used by the bit-serial datapath.
module full_add_cell (
  input  logic A,
  input  logic B,
  input  logic CI,
  output logic S,
  output logic CO
);

  assign S  = A ^ B ^ CI;
  assign CO = (A & B) | (CI & (A ^ B));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: SUM = A + B + CIN, LSB first, one bit per clock through a single full-add cell.
module serial_adder
  import arithmetic_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         START,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         CIN,
  output logic         BUSY,
  output logic         DONE,
  output logic [N-1:0] SUM,
  output logic         COUT
);

  localparam int unsigned CW = cnt_width(N);

  state_t         state_q, state_d;
  logic [N-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic           c_q, c_d, cout_q, cout_d;
  logic           busy_q, busy_d, done_q, done_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           s_c, co_c;

  full_add_cell u_fa (
    .A  (a_q[0]),
    .B  (b_q[0]),
    .CI (c_q),
    .S  (s_c),
    .CO (co_c)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: capture on START in IDLE, one full-add step per RUN cycle, single DONE cycle.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    c_d     = c_q;
    cout_d  = cout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (START) begin
          a_d     = A;
          b_d     = B;
          c_d     = CIN;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        sum_d = {s_c, sum_q[N-1:1]};
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        c_d   = co_c;
        cnt_d = CW'(cnt_q + 1'b1);
        if (cnt_q == CW'(N - 1)) begin
          cout_d  = co_c;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign BUSY = busy_q;
  assign DONE = done_q;
  assign SUM  = sum_q;
  assign COUT = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at N=8 and N=16 against a cycle-level arithmetic model.
module tb_serial_adder;

  logic        clk, rst_n;
  logic        start8, cin8, busy8, done8, cout8;
  logic [7:0]  a8, b8, sum8;
  logic        start16, cin16, busy16, done16, cout16;
  logic [15:0] a16, b16, sum16;

  int errors = 0;
  int checks = 0;

  // Model: remaining busy cycles, DONE-cycle flag, last completed result {cout,sum}, pending result.
  int          m_cnt[2];
  bit          m_done[2];
  int unsigned m_res[2];
  int unsigned m_pend[2];
  int          done_cnt[2];

  serial_adder #(.N(8)) u_dut8 (
    .CLK(clk), .RST_N(rst_n), .START(start8), .A(a8), .B(b8), .CIN(cin8),
    .BUSY(busy8), .DONE(done8), .SUM(sum8), .COUT(cout8)
  );

  serial_adder #(.N(16)) u_dut16 (
    .CLK(clk), .RST_N(rst_n), .START(start16), .A(a16), .B(b16), .CIN(cin16),
    .BUSY(busy16), .DONE(done16), .SUM(sum16), .COUT(cout16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_step(input int i, input bit st, input int unsigned av, input int unsigned bv,
                        input bit cv, input int w);
    if (m_done[i]) begin
      m_done[i] = 1'b0;
    end else if (m_cnt[i] > 0) begin
      m_cnt[i]--;
      if (m_cnt[i] == 0) begin
        m_done[i] = 1'b1;
        m_res[i]  = m_pend[i];
      end
    end else if (st) begin
      m_pend[i] = av + bv + 32'(cv);
      m_cnt[i]  = w;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_cnt[i] = 0; m_done[i] = 1'b0; m_res[i] = 0; m_pend[i] = 0;
      end
    end else begin
      m_step(0, start8, 32'(a8), 32'(b8), cin8, 8);
      m_step(1, start16, 32'(a16), 32'(b16), cin16, 16);
    end
  end

  task automatic cmp(input int i, input int w, input logic busy, input logic done,
                     input logic [15:0] sum, input logic cout);
    int unsigned mask;
    mask = (32'd1 << w) - 1;
    chk($sformatf("busy_n%0d", w), 32'(busy), 32'(m_cnt[i] > 0));
    chk($sformatf("done_n%0d", w), 32'(done), 32'(m_done[i]));
    if (m_cnt[i] == 0) begin
      chk($sformatf("sum_n%0d", w), 32'(sum), m_res[i] & mask);
      chk($sformatf("cout_n%0d", w), 32'(cout), (m_res[i] >> w) & 32'd1);
    end
    if (done) done_cnt[i]++;
  endtask

  // Compare process: every falling edge, both instances against the model.
  always @(negedge clk) begin
    cmp(0, 8, busy8, done8, {8'h00, sum8}, cout8);
    cmp(1, 16, busy16, done16, sum16, cout16);
  end

  // Directed 8-bit op: returns edges from START edge to DONE and number of BUSY cycles.
  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                     output int edges, output int busy_n);
    @(negedge clk); #1;
    a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
    @(negedge clk);
    busy_n = int'(busy8);
    #1 start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    edges = 0;
    while (edges < 40) begin
      @(negedge clk);
      edges++;
      busy_n += int'(busy8);
      if (done8) break;
    end
  endtask

  int e, bn, d0, d1, budget;

  initial begin
    rst_n = 1'b1;
    start8 = 1'b0; start16 = 1'b0;
    a8 = '0; b8 = '0; cin8 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
    done_cnt[0] = 0; done_cnt[1] = 0;
    #3 rst_n = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'b1; start8 = 1'b1;
    a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'b1; start16 = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", 32'(busy8), 0);
    chk("rst_done", 32'(done8), 0);
    chk("rst_sum", 32'(sum8), 0);
    chk("rst_cout", 32'(cout8), 0);
    start8 = 1'b0; start16 = 1'b0;
    rst_n = 1'b1;
    d0 = done_cnt[0];
    repeat (3) @(negedge clk);
    #1 chk("idle_no_done", 32'(done_cnt[0] - d0), 0);

    // Basic add
    op8(8'h35, 8'h4A, 1'b0, e, bn);
    chk("basic_latency", 32'(e), 8);
    chk("basic_busy_cycles", 32'(bn), 8);
    chk("basic_sum", 32'(sum8), 32'h7F);
    chk("basic_cout", 32'(cout8), 0);
    chk("model_basic", m_res[0], 32'h07F);

    // Carry ripple through every bit
    op8(8'hFF, 8'h00, 1'b1, e, bn);
    chk("ripple1_sum", 32'(sum8), 32'h00);
    chk("ripple1_cout", 32'(cout8), 1);
    chk("model_ripple1", m_res[0], 32'h100);
    op8(8'hFF, 8'hFF, 1'b1, e, bn);
    chk("ripple2_sum", 32'(sum8), 32'hFF);
    chk("ripple2_cout", 32'(cout8), 1);

    // START ignored during RUN and during the DONE cycle
    repeat (2) @(negedge clk);
    #1 d0 = done_cnt[0];
    a8 = 8'h10; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk); #1 start8 = 1'b0;
    repeat (3) @(negedge clk);
    #1 a8 = 8'hAA; start8 = 1'b1;
    @(negedge clk); #1 start8 = 1'b0;
    e = 0;
    while (e < 40 && !done8) begin @(negedge clk); e++; end
    #1 a8 = 8'hAA; start8 = 1'b1;
    @(negedge clk); #1 start8 = 1'b0;
    repeat (12) @(negedge clk);
    #1 chk("busyprot_single_done", 32'(done_cnt[0] - d0), 1);
    chk("busyprot_sum", 32'(sum8), 32'h11);
    op8(8'h20, 8'h03, 1'b0, e, bn);
    chk("after_prot_latency", 32'(e), 8);
    chk("after_prot_sum", 32'(sum8), 32'h23);

    // Abort mid-RUN
    @(negedge clk); #1;
    a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk); #1 start8 = 1'b0;
    d0 = done_cnt[0];
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy8), 0);
    chk("abort_done", 32'(done8), 0);
    chk("abort_sum", 32'(sum8), 0);
    chk("abort_cout", 32'(cout8), 0);
    @(negedge clk); #1 rst_n = 1'b1;
    repeat (12) @(negedge clk);
    #1 chk("abort_no_done", 32'(done_cnt[0] - d0), 0);
    op8(8'h02, 8'h03, 1'b0, e, bn);
    chk("post_abort_sum", 32'(sum8), 32'h05);
    chk("post_abort_latency", 32'(e), 8);

    // Randomized back-to-back: START held high, fresh operands each cycle
    @(negedge clk); #1;
    d0 = done_cnt[0]; d1 = done_cnt[1];
    budget = 0;
    while (budget < 12000 && ((done_cnt[0] - d0) < 500 || (done_cnt[1] - d1) < 50)) begin
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); start8 = 1'b1;
      a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom); start16 = 1'b1;
      @(negedge clk); #1;
      budget++;
    end
    start8 = 1'b0; start16 = 1'b0;
    chk("rand_ops_n8", 32'((done_cnt[0] - d0) >= 500), 1);
    chk("rand_ops_n16", 32'((done_cnt[1] - d1) >= 50), 1);
    repeat (24) @(negedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder, computing SUM = A + B + CIN, LSB first, one bit per clock.
- Complements the team's bit-level subtract datapath: it is the addition direction of the same full-cell arithmetic.
- A single registered 1-bit full-add cell with a carry flip-flop replaces an N-bit ripple chain, trading latency for area.
- Sits between a register-file/controller issuing START and a consumer that waits on DONE.

Parameters:
- N, 8, operand and sum width in bits (N >= 2).

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- START  input  1  request; sampled only while BUSY=0.
- A  input  N  augend; captured on accepted START.
- B  input  N  addend; captured on accepted START.
- CIN  input  1  carry-in; captured on accepted START.
- BUSY  output  1  high while an operation is in progress.
- DONE  output  1  one-cycle pulse, result valid.
- SUM  output  N  result, held until the next accepted START.
- COUT  output  1  carry-out of bit N-1, held with SUM.

Behaviour:
- Interface: one clock (CLK); reset is asynchronous and active-low (RST_N). Reset acts immediately on assertion, independent of CLK.
- Reset values: state=IDLE, BUSY=0, DONE=0, SUM=0, COUT=0, carry FF=0, bit counter=0, operand shift registers=0.
- States:
  - IDLE:
    - START=1 at edge k captures A and B into shift registers and CIN into the carry FF.
    - Counter clears to 0; goes to RUN. BUSY=1 from edge k.
  - RUN, each edge:
    - s = a0^b0^c; c' = a0&b0 | c&(a0^b0).
    - s shifts into the SUM shift register from the MSB side; A and B shift right by one; counter increments.
    - When the counter reaches N-1 (i.e. at edge k+N), the last bit is processed, COUT <= c', state goes to DONE.
  - DONE:
    - DONE=1 and BUSY=0 for exactly one cycle (the cycle after edge k+N).
    - Next edge returns to IDLE.
- Latency: START sampled at edge k → DONE high in the cycle after edge k+N. Back-to-back throughput is one op per N+2 cycles.
- SUM is bit-exact at DONE. SUM/COUT are not required to be meaningful while BUSY=1 (partial shifting is visible); they are stable from DONE until the next accepted START.
- START while BUSY=1 or during DONE: ignored, no queuing. START in the DONE cycle is not accepted; the requester must reassert it in IDLE.
- A, B, CIN changing after acceptance: no effect.
- Arithmetic: unsigned modulo 2^N; overflow is reported only via COUT. Signed use is the caller's concern.
- Wrap-around: the all-ones + 1 case must propagate carry through every bit (no early-termination logic).
- RST_N asserted mid-RUN: immediate abort to reset values; no DONE pulse. After release, IDLE accepts a new START.

Decomposition:
- Shared package, arithmetic_pkg:
  - state encoding constants (IDLE, RUN, DONE);
  - counter width localparam CNT_W = $clog2(N).
- Sub-module full_add_cell: combinational 1-bit full adder (A, B, CI → S, CO), instantiated once inside the datapath.
- The carry FF, counter and FSM stay in serial_adder.

Test Plan:
- Reset: drive RST_N=0 with random inputs → BUSY=0, DONE=0, SUM=8'h00, COUT=0. Release, idle 3 cycles → no DONE.
- Basic add: A=8'h35, B=8'h4A, CIN=0, START one cycle → DONE exactly 8 cycles after the START edge, SUM=8'h7F, COUT=0, BUSY high for 8 cycles.
- Full carry ripple: A=8'hFF, B=8'h00, CIN=1 → SUM=8'h00, COUT=1. Then A=8'hFF, B=8'hFF, CIN=1 → SUM=8'hFF, COUT=1.
- Busy protection: START with A=8'h10, B=8'h01; re-pulse START with A=8'hAA during RUN and again during the DONE cycle → single DONE, SUM=8'h11. Next START in IDLE is accepted normally.
- Abort: START A=8'h0F, B=8'h01, assert RST_N at cycle 4 of RUN → outputs at reset values immediately, no DONE. After release, A=8'h02, B=8'h03 → SUM=8'h05.
- Randomized: 500 random A/B/CIN ops at N=8 plus 50 at N=16 → {COUT,SUM} == A+B+CIN every time; back-to-back ops spaced N+2 cycles.
